// File: rtl/types.sv
// Shared definitions for the board input front ends: debounce FSM states and
// the default debounce window (10 ms at 100 MHz).
package types;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } debounce_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  // A channel still reads high while it is qualifying a possible release.
  function automatic logic state_is_high(input debounce_state_t state);
    return (state == STABLE_HIGH) || (state == WAIT_LOW);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchroniser, debounce FSM with stability counter, and
// registered level / press / release outputs.
module debounce_channel
  import types::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("debounce_channel: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("debounce_channel: DEBOUNCE_CYCLES must be >= 2");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  debounce_state_t        state;
  logic [CNT_W-1:0]       cnt;
  logic                   high_now;

  assign sync     = sync_q[SYNC_STAGES-1];
  assign high_now = state_is_high(state);

  // Outputs trail the FSM state by one edge so press/release line up exactly
  // with the first cycle of the new level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      state     <= STABLE_LOW;
      cnt       <= '0;
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], raw_i};
      level_o   <= high_now;
      press_o   <= high_now & ~level_o;
      release_o <= ~high_now & level_o;

      unique case (state)
        STABLE_LOW: begin
          if (sync) begin
            state <= WAIT_HIGH;
            cnt   <= CNT_ONE;
          end
        end
        WAIT_HIGH: begin
          if (!sync) begin
            state <= STABLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!sync) begin
            state <= WAIT_LOW;
            cnt   <= CNT_ONE;
          end
        end
        WAIT_LOW: begin
          if (sync) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_LOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= STABLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Board push-button / switch front end: N independent synchronise-and-debounce
// channels producing clean levels plus single-cycle press and release pulses.
module button_conditioner
  import types::*;
#(
  parameter int N_CHANNELS      = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_CHANNELS-1:0] raw_i,
  output logic [N_CHANNELS-1:0] level_o,
  output logic [N_CHANNELS-1:0] press_o,
  output logic [N_CHANNELS-1:0] release_o
);

  generate
    if (N_CHANNELS < 1) begin : g_bad_channels
      $error("button_conditioner: N_CHANNELS must be >= 1");
    end
  endgenerate

  for (genvar ch = 0; ch < N_CHANNELS; ch++) begin : g_channel
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_channel (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .raw_i     (raw_i[ch]),
      .level_o   (level_o[ch]),
      .press_o   (press_o[ch]),
      .release_o (release_o[ch])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a short debounce window; inputs
// change and outputs are sampled on the falling clock edge.
module tb_button_conditioner;

  localparam int N   = 4;
  localparam int S   = 2;
  localparam int D   = 8;
  localparam int LAT = S + D;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] raw;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] rel;

  int           errors = 0;
  int           checks = 0;
  bit           monitorOn = 1'b0;
  logic [N-1:0] prevPress = '0;
  logic [N-1:0] prevRel = '0;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_CHANNELS      (N),
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .raw_i     (raw),
    .level_o   (level),
    .press_o   (press),
    .release_o (rel)
  );

  task automatic checkOutput(input string tag, input logic [N-1:0] observed,
                             input logic [N-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] value);
    raw = value;
  endtask

  // Each tick passes exactly one rising edge and lands on the next falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse invariants watched on every cycle while the directed tests run.
  always @(negedge clk) begin
    if (monitorOn) begin
      checkOutput("mon_press_and_release", press & rel, '0);
      checkOutput("mon_press_implies_level", press & ~level, '0);
      checkOutput("mon_pulse_width", (press & prevPress) | (rel & prevRel), '0);
      prevPress = press;
      prevRel   = rel;
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus('0);
    tick(2);
    checkOutput("reset_level", level, '0);
    checkOutput("reset_press", press, '0);
    checkOutput("reset_release", rel, '0);
    rst = 1'b0;
    monitorOn = 1'b1;
    tick(2);

    // 1. Clean press and release on channel 0
    applyStimulus(4'b0001);
    for (int i = 0; i < LAT; i++) begin
      tick(1);
      checkOutput("t1_level_before_press", level, 4'b0000);
      checkOutput("t1_press_early", press, 4'b0000);
    end
    tick(1);
    checkOutput("t1_press_pulse", press, 4'b0001);
    checkOutput("t1_level_high", level, 4'b0001);
    checkOutput("t1_no_release", rel, 4'b0000);
    tick(1);
    checkOutput("t1_press_one_cycle", press, 4'b0000);
    checkOutput("t1_level_held", level, 4'b0001);
    tick(8);
    applyStimulus(4'b0000);
    for (int i = 0; i < LAT; i++) begin
      tick(1);
      checkOutput("t1_level_before_release", level, 4'b0001);
      checkOutput("t1_release_early", rel, 4'b0000);
    end
    tick(1);
    checkOutput("t1_release_pulse", rel, 4'b0001);
    checkOutput("t1_level_low", level, 4'b0000);
    tick(1);
    checkOutput("t1_release_one_cycle", rel, 4'b0000);
    tick(3);

    // 2. Seven-cycle glitch on channel 1 is rejected
    applyStimulus(4'b0010);
    for (int i = 0; i < 7; i++) begin
      tick(1);
      checkOutput("t2_quiet_high", level | press | rel, 4'b0000);
    end
    applyStimulus(4'b0000);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checkOutput("t2_quiet_low", level | press | rel, 4'b0000);
    end

    // 3. Bounce train on channel 2, then a steady hold
    for (int b = 0; b < 2; b++) begin
      applyStimulus(4'b0100);
      tick(2);
      checkOutput("t3_bounce_high", level | press, 4'b0000);
      applyStimulus(4'b0000);
      tick(2);
      checkOutput("t3_bounce_low", level | press, 4'b0000);
    end
    applyStimulus(4'b0100);
    for (int i = 0; i < LAT; i++) begin
      tick(1);
      checkOutput("t3_press_early", press | level, 4'b0000);
    end
    tick(1);
    checkOutput("t3_press_pulse", press, 4'b0100);
    checkOutput("t3_level_high", level, 4'b0100);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      checkOutput("t3_single_press", press, 4'b0000);
    end
    applyStimulus(4'b0000);
    tick(LAT + 3);
    checkOutput("t3_level_back_low", level, 4'b0000);

    // 4. All channels together, then a partial release
    applyStimulus(4'b1111);
    for (int i = 0; i < LAT; i++) begin
      tick(1);
      checkOutput("t4_press_early", press, 4'b0000);
    end
    tick(1);
    checkOutput("t4_press_all", press, 4'b1111);
    checkOutput("t4_level_all", level, 4'b1111);
    tick(1);
    checkOutput("t4_press_cleared", press, 4'b0000);
    tick(5);
    applyStimulus(4'b0101);
    for (int i = 0; i < LAT; i++) begin
      tick(1);
      checkOutput("t4_release_early", rel, 4'b0000);
    end
    tick(1);
    checkOutput("t4_release_odd", rel, 4'b1010);
    checkOutput("t4_level_even", level, 4'b0101);
    checkOutput("t4_no_press", press, 4'b0000);
    tick(1);
    checkOutput("t4_release_cleared", rel, 4'b0000);
    applyStimulus(4'b0000);
    tick(LAT + 3);
    checkOutput("t4_level_back_low", level, 4'b0000);

    // 5. Reset at count 5 of a press on channel 0, pin kept high
    applyStimulus(4'b0001);
    tick(7);
    checkOutput("t5_still_waiting", level | press, 4'b0000);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("t5_reset_outputs", level | press | rel, 4'b0000);
    for (int i = 0; i < LAT; i++) begin
      tick(1);
      checkOutput("t5_quiet_after_reset", level | press | rel, 4'b0000);
    end
    tick(1);
    checkOutput("t5_press_after_reset", press, 4'b0001);
    checkOutput("t5_level_after_reset", level, 4'b0001);
    tick(3);

    // Reset while the level is high: no release pulse, then a fresh press
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("t5_reset_high_level", level, 4'b0000);
    checkOutput("t5_reset_no_release", rel, 4'b0000);
    for (int i = 0; i < LAT; i++) begin
      tick(1);
      checkOutput("t5_quiet_second", level | press | rel, 4'b0000);
    end
    tick(1);
    checkOutput("t5_second_press", press, 4'b0001);
    tick(2);

    monitorOn = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
